riscv_decode_stage: RTL
=======================

Name: riscv_decode_stage

Overview:
- Registered instruction-decode stage for the RV32I/RV64I core, parametrised on XLEN (32 or 64).
- Accepts a fetched instruction and PC over a valid/ready handshake.
- Classifies the opcode, extracts register fields, builds the XLEN-wide sign-extended immediate and flags illegal encodings.
- Output goes through a 2-entry skid buffer, so the stage sustains one instruction per cycle under back-pressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. 64 also enables the LD/LWU/SD and OP-32/OP-IMM-32 encodings.
- PC_W, XLEN, width of the PC passthrough.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous: discard all buffered entries
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  consumer accepts
- out_dec  out  $bits(decoded_t)  decoded bundle: cls, funct3, rd, rs1, rs2, imm[XLEN-1:0], alt (instr[30]), is_word, illegal, pc, csr[11:0]

Behaviour:
- Reset (async, rst=1): both buffer entries invalid; out_valid=0, out_dec=0, in_ready=1.
- Transfers: an input transfer happens when in_valid&&in_ready; an output transfer when out_valid&&out_ready.
- Latency: an instruction accepted in cycle N appears on out_valid in cycle N+1 at the earliest. Decode is combinational on in_instr and is registered into the buffer.
- Buffer states: EMPTY, ONE, FULL.
  - in_ready = (state != FULL). This is a registered decision and has no combinational path from out_ready.
  - EMPTY + input transfer -> ONE.
  - ONE + input transfer + output transfer -> ONE.
  - ONE + input transfer only -> FULL.
  - ONE + output transfer only -> EMPTY.
  - FULL + output transfer -> ONE.
  - Order is strictly FIFO.
- flush:
  - Next state is EMPTY and out_valid=0 the following cycle.
  - Any input transfer in the flush cycle is dropped.
  - flush has priority over every other event.
- Stability: while out_valid && !out_ready, out_dec is held stable.
- Immediates: I, S, B, U, J formats, sign-extended from instr[31] to XLEN. U-type is instr[31:12]<<12, sign-extended for XLEN=64.
- Illegal (illegal=1, cls=ILLEGAL, imm=0, other fields still extracted) when any of:
  - instr[1:0] != 2'b11.
  - Unknown opcode[6:2].
  - JALR funct3 != 000.
  - BRANCH funct3 010/011.
  - LOAD funct3 011 or 110 with XLEN=32; 111 always.
  - STORE funct3 > 010 with XLEN=32, or > 011 with XLEN=64.
  - OP funct7 is not 0000000, and is not 0100000 with funct3 ADD/SR.
  - OP-IMM shifts:
    - XLEN=32: instr[31:25] must be 0000000, or 0100000 for SR.
    - XLEN=64: instr[31:26] must be 000000 or 010000, with shamt[5] allowed.
  - OP-32/OP-IMM-32 with XLEN=32.
  - SYSTEM other than ECALL/EBREAK (see optional feature).
- is_word: set for OP-32/OP-IMM-32 (XLEN=64 only).
- alt: instr[30] for OP and SR-type shifts, 0 otherwise.

Optional Feature:
- Macro: RV_ZICSR_EN.
- Defined: SYSTEM funct3 CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI decode as cls=CSR, csr=instr[31:20]. For the immediate forms, imm = zero-extended rs1 field.
- Undefined: those encodings are illegal and the csr field is tied to 0.

Decomposition:
- Add to riscv_pkg:
  - OP_ALU_IMM_W=5'b00110, OP_ALU_W=5'b01110.
  - F3_LOAD_LD=3'b011, F3_LOAD_LWU=3'b110, F3_STORE_SD=3'b011.
  - instr_class_e enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU_IMM, ALU, MISC_MEM, SYSTEM, CSR, ILLEGAL.
  - decoded_t packed struct, parametrised via XLEN.
- Sub-module: riscv_skid_buffer, a generic WIDTH-parametrised 2-entry valid/ready buffer with flush. The decode logic is a combinational function in the top module.

Test Plan:
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> next cycle out_valid=1, cls=ALU_IMM, rd=1, rs1=0, imm=0xFFFFFFFF, illegal=0.
- Back-pressure: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 on cycle 3. Raise out_ready -> outputs in order, none lost or duplicated.
- 0x0000B083 (ld x1,0(x1)) -> XLEN=64: cls=LOAD, illegal=0; XLEN=32: illegal=1, imm=0.
- 0x02009093 (slli x1,x1,32) -> XLEN=32: illegal=1; XLEN=64: legal, imm[5:0]=32.
- FULL state, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- 0x34011073 (csrrw x0,0x340,x2) -> with RV_ZICSR_EN: cls=CSR, csr=0x340, rs1=2; without: illegal=1. Assert rst mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: opcode/funct3 constants, instruction classes and the decoded bundle.
// decoded_t is sized for the widest core (XLEN_MAX); only imm[XLEN-1:0] and pc[PC_W-1:0] carry data.
package riscv_pkg;

    localparam int unsigned XLEN_MAX = 64;
    localparam int unsigned PC_MAX   = 64;

    localparam logic [4:0] OP_LOAD      = 5'b00000;
    localparam logic [4:0] OP_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OP_ALU_IMM   = 5'b00100;
    localparam logic [4:0] OP_AUIPC     = 5'b00101;
    localparam logic [4:0] OP_ALU_IMM_W = 5'b00110;
    localparam logic [4:0] OP_STORE     = 5'b01000;
    localparam logic [4:0] OP_ALU       = 5'b01100;
    localparam logic [4:0] OP_LUI       = 5'b01101;
    localparam logic [4:0] OP_ALU_W     = 5'b01110;
    localparam logic [4:0] OP_BRANCH    = 5'b11000;
    localparam logic [4:0] OP_JALR      = 5'b11001;
    localparam logic [4:0] OP_JAL       = 5'b11011;
    localparam logic [4:0] OP_SYSTEM    = 5'b11100;

    localparam logic [2:0] F3_LOAD_LD   = 3'b011;
    localparam logic [2:0] F3_LOAD_LWU  = 3'b110;
    localparam logic [2:0] F3_STORE_SD  = 3'b011;
    localparam logic [2:0] F3_STORE_SW  = 3'b010;
    localparam logic [2:0] F3_ADD       = 3'b000;
    localparam logic [2:0] F3_SLL       = 3'b001;
    localparam logic [2:0] F3_SR        = 3'b101;
    localparam logic [2:0] F3_PRIV      = 3'b000;

    localparam logic [6:0] F7_BASE      = 7'b0000000;
    localparam logic [6:0] F7_ALT       = 7'b0100000;

    typedef enum logic [3:0] {
        LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
        ALU_IMM, ALU, MISC_MEM, SYSTEM, CSR, ILLEGAL
    } instr_class_e;

    typedef enum logic [1:0] {
        BUF_EMPTY, BUF_ONE, BUF_FULL
    } buf_state_e;

    typedef struct packed {
        instr_class_e          cls;
        logic [2:0]            funct3;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [XLEN_MAX-1:0]   imm;
        logic                  alt;
        logic                  is_word;
        logic                  illegal;
        logic [PC_MAX-1:0]     pc;
        logic [11:0]           csr;
    } decoded_t;

    // Clear bits above XLEN so an RV32 bundle carries only its 32-bit immediate.
    function automatic logic [XLEN_MAX-1:0] imm_fit(input logic [XLEN_MAX-1:0] imm,
                                                     input int unsigned      xlen);
        logic [XLEN_MAX-1:0] res;
        res = imm;
        if (xlen == 32) begin
            res = {32'b0, imm[31:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_skid_buffer.sv
// Generic two-entry FIFO-ordered valid/ready skid buffer with synchronous flush.
// Both handshake outputs are registered, so in_ready_o has no path from out_ready_i.
module riscv_skid_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             in_xfer_c;
    logic             out_xfer_c;

    assign in_xfer_c  = in_valid_i && ready_q;
    assign out_xfer_c = valid_q && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Head always drives the output; tail only fills while the head is stalled.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (in_xfer_c) begin
                        head_d  = in_data_i;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_xfer_c && out_xfer_c) begin
                        head_d = in_data_i;
                    end else if (in_xfer_c) begin
                        tail_d  = in_data_i;
                        state_d = BUF_FULL;
                    end else if (out_xfer_c) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_xfer_c) begin
                        head_d  = tail_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
        ready_d = (state_d != BUF_FULL);
        valid_d = (state_d != BUF_EMPTY);
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I/RV64I decode stage: combinational decode into a 2-entry skid buffer.
// Optional Zicsr decode is enabled by defining RV_ZICSR_EN.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output decoded_t        out_dec
);

    localparam int unsigned DEC_W = $bits(decoded_t);
    localparam bit          RV64  = (XLEN == 64);

    // RV32 shift-immediate encoding check, also used by the RV64 word shifts.
    function automatic logic shift32_ok(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == F7_BASE) || ((f3 == F3_SR) && (f7 == F7_ALT));
    endfunction

    function automatic decoded_t decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        decoded_t            d;
        logic [4:0]          opc;
        logic [2:0]          f3;
        logic [6:0]          f7;
        logic                ill;
        logic                alt;
        logic                is_word;
        logic [11:0]         csr;
        instr_class_e        cls;
        logic [XLEN_MAX-1:0] imm;
        logic [XLEN_MAX-1:0] imm_i;
        logic [XLEN_MAX-1:0] imm_s;
        logic [XLEN_MAX-1:0] imm_b;
        logic [XLEN_MAX-1:0] imm_u;
        logic [XLEN_MAX-1:0] imm_j;

        opc   = ins[6:2];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = {{52{ins[31]}}, ins[31:20]};
        imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
        imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

        cls     = ILLEGAL;
        imm     = '0;
        ill     = 1'b0;
        alt     = 1'b0;
        is_word = 1'b0;
        csr     = '0;

        case (opc)
            OP_LUI:   begin cls = LUI;   imm = imm_u; end
            OP_AUIPC: begin cls = AUIPC; imm = imm_u; end
            OP_JAL:   begin cls = JAL;   imm = imm_j; end
            OP_JALR: begin
                cls = JALR;
                imm = imm_i;
                ill = (f3 != 3'b000);
            end
            OP_BRANCH: begin
                cls = BRANCH;
                imm = imm_b;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_LOAD: begin
                cls = LOAD;
                imm = imm_i;
                ill = (f3 == 3'b111) || (!RV64 && ((f3 == F3_LOAD_LD) || (f3 == F3_LOAD_LWU)));
            end
            OP_STORE: begin
                cls = STORE;
                imm = imm_s;
                ill = RV64 ? (f3 > F3_STORE_SD) : (f3 > F3_STORE_SW);
            end
            OP_ALU_IMM: begin
                cls = ALU_IMM;
                imm = imm_i;
                if ((f3 == F3_SLL) || (f3 == F3_SR)) begin
                    alt = (f3 == F3_SR) ? ins[30] : 1'b0;
                    if (RV64) begin
                        ill = !((ins[31:26] == 6'b000000) || (ins[31:26] == 6'b010000));
                    end else begin
                        ill = !shift32_ok(f3, f7);
                    end
                end
            end
            OP_ALU: begin
                cls = ALU;
                alt = ins[30];
                ill = !((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            OP_ALU_IMM_W: begin
                cls     = ALU_IMM;
                imm     = imm_i;
                is_word = RV64;
                alt     = (f3 == F3_SR) ? ins[30] : 1'b0;
                ill     = !RV64
                        || ((f3 != F3_ADD) && (f3 != F3_SLL) && (f3 != F3_SR))
                        || ((f3 != F3_ADD) && !shift32_ok(f3, f7));
            end
            OP_ALU_W: begin
                cls     = ALU;
                is_word = RV64;
                alt     = ins[30];
                ill     = !RV64
                        || !(((f7 == F7_BASE) && ((f3 == F3_ADD) || (f3 == F3_SLL) || (f3 == F3_SR)))
                          || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            OP_MISC_MEM: begin
                cls = MISC_MEM;
                imm = imm_i;
            end
            OP_SYSTEM: begin
                if (f3 == F3_PRIV) begin
                    // Only ECALL (imm 0) and EBREAK (imm 1) with zero rd/rs1.
                    cls = SYSTEM;
                    imm = imm_i;
                    ill = !((ins[11:7] == 5'd0) && (ins[19:15] == 5'd0) && (ins[31:21] == 11'd0));
                end else begin
`ifdef RV_ZICSR_EN
                    cls = CSR;
                    csr = ins[31:20];
                    imm = f3[2] ? XLEN_MAX'(ins[19:15]) : '0;
                    ill = (f3 == 3'b100);
`else
                    ill = 1'b1;
`endif
                end
            end
            default: ill = 1'b1;
        endcase

        if (ins[1:0] != 2'b11) begin
            ill = 1'b1;
        end
        if (ill) begin
            cls = ILLEGAL;
            imm = '0;
            csr = '0;
        end

        d.cls     = cls;
        d.funct3  = f3;
        d.rd      = ins[11:7];
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        d.imm     = imm_fit(imm, XLEN);
        d.alt     = alt;
        d.is_word = is_word;
        d.illegal = ill;
        d.pc      = PC_MAX'(pc);
        d.csr     = csr;
        return d;
    endfunction

    decoded_t         dec_c;
    logic [DEC_W-1:0] buf_data;

    assign dec_c = decode(in_instr, in_pc);

    riscv_skid_buffer #(
        .WIDTH(DEC_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (DEC_W'(dec_c)),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (buf_data)
    );

    assign out_dec = decoded_t'(buf_data);

endmodule
